opb_register_simulink2ppc_snap64: RTL and testbench



---
 rtl/opb_register_simulink2ppc_snap64_if.sv | 25 ++
 rtl/opb_register_simulink2ppc_snap64.sv | 128 ++++++++++++
 tb/tb_opb_register_simulink2ppc_snap64.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/opb_register_simulink2ppc_snap64_if.sv
// OPB slave-side bus bundle: master request signals and slave response signals.
// Bit 0 of each OPB vector is the most significant bit.
interface opb_register_simulink2ppc_snap64_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_simulink2ppc_snap64.sv
// Purpose: OPB readback of a 64-bit fabric value; low-word read freezes the high word.
// Latency: xferAck two edges after OPB_select is first sampled, one-cycle ack, one GAP cycle.
// Backpressure: none; user strobes are always accepted, the master waits for xferAck.
module opb_register_simulink2ppc_snap64 #(
    parameter logic [31:0] C_BASEADDR   = 32'h01000200,
    parameter logic [31:0] C_HIGHADDR   = 32'h010002FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5"
) (
    input  logic                                 OPB_Clk,
    input  logic                                 OPB_Rst,
    opb_register_simulink2ppc_snap64_if.slave    opb,
    input  logic [63:0]                          user_data_in,
    input  logic                                 user_data_valid,
    output logic                                 user_read_strobe
);
    typedef enum logic [1:0] {IDLE, ACK, GAP} state_t;

    state_t                    state;
    logic [C_OPB_AWIDTH-1:0]   addr;
    logic                      hit;
    logic                      hit_q;
    logic                      rnw_q;
    logic                      low_q;
    logic [1:0]                idx_q;
    logic [63:0]               live;
    logic [31:0]               hi_shadow;
    logic [15:0]               cnt;
    logic                      seen;
    logic [15:0]               cnt_nxt;
    logic                      seen_nxt;
    logic [C_OPB_DWIDTH-1:0]   rd_word;
    logic [C_OPB_DWIDTH-1:0]   dbus_q;
    logic                      ack_q;
    logic                      rd_low;
    logic                      unused_bits;

    assign addr = opb.OPB_ABus;
    assign hit  = opb.OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

    // Snapshot read: fires on the edge that enters ACK.
    assign rd_low = (state == IDLE) && hit_q && rnw_q && low_q && (idx_q == 2'd0);

    always_comb begin
        rd_word = '0;
        case (idx_q)
            2'd0:    rd_word = live[31:0];
            2'd1:    rd_word = hi_shadow;
            2'd2:    rd_word = {seen, 15'b0, cnt};
            default: rd_word = '0;
        endcase
    end

    // Clear from the low-word read happens first, so a coincident strobe still counts.
    always_comb begin
        cnt_nxt  = cnt;
        seen_nxt = seen;
        if (rd_low) begin
            cnt_nxt  = '0;
            seen_nxt = 1'b0;
        end
        if (user_data_valid) begin
            seen_nxt = 1'b1;
            if (cnt_nxt != 16'hFFFF) cnt_nxt = cnt_nxt + 16'd1;
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state            <= IDLE;
            hit_q            <= 1'b0;
            rnw_q            <= 1'b0;
            low_q            <= 1'b0;
            idx_q            <= 2'd0;
            ack_q            <= 1'b0;
            dbus_q           <= '0;
            user_read_strobe <= 1'b0;
            live             <= '0;
            hi_shadow        <= '0;
            cnt              <= '0;
            seen             <= 1'b0;
        end else begin
            // Ignore the still-held select of the transfer currently being acked.
            if (state != ACK) begin
                hit_q <= hit;
                rnw_q <= opb.OPB_RNW;
                low_q <= (addr[7:4] == 4'd0);
                idx_q <= addr[3:2];
            end else begin
                hit_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hit_q) begin
                        state            <= ACK;
                        ack_q            <= 1'b1;
                        dbus_q           <= (rnw_q && low_q) ? rd_word : '0;
                        user_read_strobe <= rd_low;
                    end
                end
                ACK: begin
                    state            <= GAP;
                    ack_q            <= 1'b0;
                    dbus_q           <= '0;
                    user_read_strobe <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (rd_low) hi_shadow <= live[63:32];
            if (user_data_valid) live <= user_data_in;
            cnt  <= cnt_nxt;
            seen <= seen_nxt;
        end
    end

    assign opb.Sl_DBus    = dbus_q;
    assign opb.Sl_xferAck = ack_q;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    assign unused_bits = ^{opb.OPB_BE, opb.OPB_DBus, opb.OPB_seqAddr, C_FAMILY[7:0]};
endmodule

// File: tb/tb_opb_register_simulink2ppc_snap64.sv
// Bench for the 64-bit snapshot readback slave: reads are scored against a small
// register model through an expectation queue drained on every xferAck.
module tb_opb_register_simulink2ppc_snap64;
    localparam logic [31:0] BASE = 32'h01000200;
    localparam logic [31:0] HIGH = 32'h010002FF;

    typedef struct {
        logic [31:0] dat;
        logic        strb;
        logic        chk_dat;
        string       tag;
    } exp_t;

    logic        OPB_Clk;
    logic        OPB_Rst;
    logic [63:0] user_data_in;
    logic        user_data_valid;
    logic        user_read_strobe;

    opb_register_simulink2ppc_snap64_if bus ();

    opb_register_simulink2ppc_snap64 dut (
        .OPB_Clk          (OPB_Clk),
        .OPB_Rst          (OPB_Rst),
        .opb              (bus),
        .user_data_in     (user_data_in),
        .user_data_valid  (user_data_valid),
        .user_read_strobe (user_read_strobe)
    );

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    logic [63:0] m_live;
    logic [31:0] m_hi;
    logic [15:0] m_cnt;
    logic        m_seen;

    initial begin
        OPB_Clk = 1'b0;
        forever #5 OPB_Clk = ~OPB_Clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge OPB_Clk) begin
        exp_t e;
        chk("tieoff", {bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 64'd0);
        if (bus.Sl_xferAck === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                if (e.chk_dat) chk(e.tag, bus.Sl_DBus, e.dat);
                chk({e.tag, "_strobe"}, user_read_strobe, e.strb);
            end
        end else begin
            chk("dbus_idle", bus.Sl_DBus, 64'd0);
            chk("strobe_idle", user_read_strobe, 64'd0);
        end
    end

    task automatic model_pulse(input logic [63:0] d);
        m_live = d;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_seen = 1'b1;
    endtask

    task automatic pulse(input logic [63:0] d);
        model_pulse(d);
        user_data_in    = d;
        user_data_valid = 1'b1;
        @(negedge OPB_Clk);
        user_data_valid = 1'b0;
    endtask

    // Push the expected response, then run one OPB transfer and time its ack.
    task automatic xfer(input logic [31:0] addr, input logic rnw, input string tag,
                        input logic coinc, input logic [63:0] cdata);
        exp_t e;
        int   lat;
        int   acks;
        logic hit;
        logic [31:0] a;
        a   = addr;
        hit = (a >= BASE) && (a <= HIGH);
        if (hit) begin
            e.tag = tag; e.chk_dat = rnw; e.strb = 1'b0; e.dat = 32'd0;
            if (rnw && a[7:4] == 4'd0) begin
                case (a[3:2])
                    2'd0: begin e.dat = m_live[31:0]; e.strb = 1'b1; end
                    2'd1: e.dat = m_hi;
                    2'd2: e.dat = {m_seen, 15'b0, m_cnt};
                    default: e.dat = 32'd0;
                endcase
            end
            if (e.strb) begin
                m_hi = m_live[63:32]; m_cnt = 16'd0; m_seen = 1'b0;
            end
            if (coinc) model_pulse(cdata);
            sb.push_back(e);
        end
        bus.OPB_ABus   = addr;
        bus.OPB_RNW    = rnw;
        bus.OPB_DBus   = 32'hDEADBEEF;
        bus.OPB_select = 1'b1;
        if (hit) begin
            lat = 0;
            while (1) begin
                @(negedge OPB_Clk);
                lat++;
                if (coinc && lat == 1) begin user_data_in = cdata; user_data_valid = 1'b1; end
                if (coinc && lat == 2) user_data_valid = 1'b0;
                if (bus.Sl_xferAck === 1'b1 || lat >= 8) break;
            end
            chk({tag, "_lat"}, lat, 64'd2);
            if (bus.Sl_xferAck !== 1'b1) e = sb.pop_back();
        end else begin
            acks = 0;
            repeat (6) begin
                @(negedge OPB_Clk);
                if (bus.Sl_xferAck === 1'b1) acks++;
            end
            chk({tag, "_noack"}, acks, 64'd0);
        end
        bus.OPB_select = 1'b0;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_ABus   = 32'd0;
        repeat (2) @(negedge OPB_Clk);
    endtask

    task automatic rd(input logic [31:0] addr, input string tag);
        xfer(addr, 1'b1, tag, 1'b0, 64'd0);
    endtask

    initial begin
        exp_t e;
        int   lat;
        OPB_Rst = 1'b1;
        user_data_in = '0; user_data_valid = 1'b0;
        bus.OPB_ABus = '0; bus.OPB_BE = 4'hF; bus.OPB_DBus = '0;
        bus.OPB_RNW = 1'b0; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
        m_live = '0; m_hi = '0; m_cnt = '0; m_seen = 1'b0;
        repeat (3) @(negedge OPB_Clk);
        chk("rst_ack", bus.Sl_xferAck, 64'd0);
        chk("rst_dbus", bus.Sl_DBus, 64'd0);
        chk("rst_strobe", user_read_strobe, 64'd0);
        OPB_Rst = 1'b0;
        @(negedge OPB_Clk);

        rd(BASE + 32'h0, "rst_rd0");
        rd(BASE + 32'h4, "rst_rd4");
        rd(BASE + 32'h8, "rst_rd8");

        pulse(64'h1122334455667788);
        rd(BASE + 32'h0, "snap_lo");
        rd(BASE + 32'h4, "snap_hi");

        pulse(64'h0000000A0000000B);
        pulse(64'h0000000C0000000D);
        pulse(64'h0000000100000002);
        rd(BASE + 32'h8, "status3");
        rd(BASE + 32'h0, "lo_clear");
        rd(BASE + 32'h8, "status_clr");

        xfer(BASE + 32'h0, 1'b1, "coinc_lo", 1'b1, 64'hAAAABBBBCCCCDDDD);
        rd(BASE + 32'h4, "coinc_hi");
        rd(BASE + 32'h8, "coinc_status");
        rd(BASE + 32'h0, "new_lo");
        rd(BASE + 32'h4, "new_hi");

        xfer(BASE + 32'h0, 1'b0, "wr0", 1'b0, 64'd0);
        rd(BASE + 32'h0, "after_wr");
        rd(BASE + 32'hC, "rd_c");
        rd(BASE + 32'h10, "rd_10");
        rd(HIGH - 32'h3, "rd_top");
        rd(32'h01000300, "miss_hi");
        rd(BASE - 32'h4, "miss_lo");

        user_data_in = 64'h0123456789ABCDEF;
        user_data_valid = 1'b1;
        repeat (70000) @(negedge OPB_Clk);
        user_data_valid = 1'b0;
        m_live = 64'h0123456789ABCDEF; m_cnt = 16'hFFFF; m_seen = 1'b1;
        rd(BASE + 32'h8, "sat");
        rd(BASE + 32'h0, "sat_lo");
        pulse(64'h0000005500000055);

        // Reset lands in the ACK cycle of a status read.
        e.tag = "rst_in_ack"; e.chk_dat = 1'b1; e.strb = 1'b0;
        e.dat = {m_seen, 15'b0, m_cnt};
        sb.push_back(e);
        bus.OPB_ABus = BASE + 32'h8; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
        lat = 0;
        while (1) begin
            @(negedge OPB_Clk);
            lat++;
            if (bus.Sl_xferAck === 1'b1 || lat >= 8) break;
        end
        chk("rst_in_ack_lat", lat, 64'd2);
        if (bus.Sl_xferAck !== 1'b1) e = sb.pop_back();
        OPB_Rst = 1'b1;
        bus.OPB_select = 1'b0; bus.OPB_RNW = 1'b0; bus.OPB_ABus = '0;
        @(negedge OPB_Clk);
        chk("rst_ack_drop", bus.Sl_xferAck, 64'd0);
        m_live = '0; m_hi = '0; m_cnt = '0; m_seen = 1'b0;
        @(negedge OPB_Clk);
        OPB_Rst = 1'b0;
        @(negedge OPB_Clk);
        rd(BASE + 32'h0, "post_rst_lo");
        rd(BASE + 32'h4, "post_rst_hi");
        rd(BASE + 32'h8, "post_rst_status");

        repeat (4) @(negedge OPB_Clk);
        chk("sb_empty", sb.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
